// File: rtl/nand_cpu_pkg.sv
// Shared types for the nand_cpu front end.
// Holds the next-PC source select and the default vector-operand width.
package nand_cpu_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_BR,
    SEL_VEC,
    SEL_RET
  } pc_sel_e;

  localparam int NUM_VEC_DEF = 16;
  localparam int VEC_W       = $clog2(NUM_VEC_DEF);

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO of interrupt return addresses.
// The caller guarantees push and pop are never both high in one cycle.
module ret_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] top_idx;

  assign top_idx = count_q - CNT_W'(1);
  assign top     = mem_q[top_idx[IDX_W-1:0]];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (push)      count_d = count_q + CNT_W'(1);
    else if (pop)  count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  // Entry contents are meaningless until pushed, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (push) mem_q[count_q[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: increment, branch, interrupt entry/return, halt/wake,
// with a nested return stack and downstream stall.
module pc_sequencer
  import nand_cpu_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              NUM_VEC   = NUM_VEC_DEF,
  parameter int              RET_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_VEC*PC_W-1:0]        vec_table,
  input  logic                           dec_valid,
  input  logic                           dec_halt,
  input  logic                           dec_int,
  input  logic [$clog2(NUM_VEC)-1:0]     dec_vec,
  input  logic                           br_override,
  input  logic [PC_W-1:0]                br_offset,
  input  logic                           stall,
  input  logic                           wake,
  output logic [PC_W-1:0]                pc,
  output logic                           pc_valid,
  output logic                           halted,
  output logic [$clog2(RET_DEPTH+1)-1:0] int_depth,
  output logic                           stack_err
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;
  pc_sel_e         sel;
  logic            adv, push, pop, vec_ok;
  logic            stk_empty, stk_full;
  logic [PC_W-1:0] stk_top, pc_inc, vec_pc;

  assign adv    = dec_valid & ~stall & ~halted_q;
  assign pc_inc = pc_q + PC_W'(1);
  assign vec_ok = int'(dec_vec) < NUM_VEC;
  assign vec_pc = vec_table[int'(dec_vec)*PC_W +: PC_W];

  // Priority encoder: halt > return > entry > bad vector > branch > increment.
  always_comb begin
    sel      = SEL_HOLD;
    push     = 1'b0;
    pop      = 1'b0;
    halted_d = halted_q;
    err_d    = err_q;
    if (halted_q) begin
      if (wake) begin
        sel      = SEL_INC;
        halted_d = 1'b0;
      end
    end else if (adv) begin
      if (dec_halt) begin
        halted_d = 1'b1;
      end else if (dec_int) begin
        if (dec_vec == '0) begin
          if (!stk_empty) begin
            sel = SEL_RET;
            pop = 1'b1;
          end else begin
            sel   = SEL_INC;
            err_d = 1'b1;
          end
        end else if (vec_ok && !stk_full) begin
          sel  = SEL_VEC;
          push = 1'b1;
        end else begin
          sel   = SEL_INC;
          err_d = 1'b1;
        end
      end else if (br_override) begin
        sel = SEL_BR;
      end else begin
        sel = SEL_INC;
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    case (sel)
      SEL_INC: pc_d = pc_inc;
      SEL_BR:  pc_d = pc_q + br_offset;
      SEL_VEC: pc_d = vec_pc;
      SEL_RET: pc_d = stk_top;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  ret_stack #(
    .W     (PC_W),
    .DEPTH (RET_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .empty     (stk_empty),
    .full      (stk_full),
    .count     (int_depth)
  );

  assign pc        = pc_q;
  assign halted    = halted_q;
  assign pc_valid  = ~halted_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with async resets.
module tb_pc_sequencer;

  localparam int PC_W      = 16;
  localparam int NUM_VEC   = 16;
  localparam int RET_DEPTH = 2;

  logic                    clk = 1'b0;
  logic                    n_rst = 1'b1;
  logic [NUM_VEC*PC_W-1:0] vec_table;
  logic                    dec_valid, dec_halt, dec_int, br_override, stall, wake;
  logic [3:0]              dec_vec;
  logic [15:0]             br_offset;
  logic [15:0]             pc;
  logic                    pc_valid, halted, stack_err;
  logic [1:0]              int_depth;

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_W      (PC_W),
    .NUM_VEC   (NUM_VEC),
    .RET_DEPTH (RET_DEPTH),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .vec_table   (vec_table),
    .dec_valid   (dec_valid),
    .dec_halt    (dec_halt),
    .dec_int     (dec_int),
    .dec_vec     (dec_vec),
    .br_override (br_override),
    .br_offset   (br_offset),
    .stall       (stall),
    .wake        (wake),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .halted      (halted),
    .int_depth   (int_depth),
    .stack_err   (stack_err)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural state plus a queue as the return stack.
  logic [15:0] m_pc;
  logic        m_halted, m_err;
  logic [15:0] m_stk[$];
  logic [15:0] vt[NUM_VEC];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_pc = 16'h0000; m_halted = 1'b0; m_err = 1'b0; m_stk.delete();
    end else if (m_halted) begin
      if (wake) begin m_halted = 1'b0; m_pc = m_pc + 16'd1; end
    end else if (dec_valid && !stall) begin
      if (dec_halt) m_halted = 1'b1;
      else if (dec_int) begin
        if (dec_vec == 0) begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin m_pc = m_pc + 16'd1; m_err = 1'b1; end
        end else if (m_stk.size() < RET_DEPTH) begin
          m_stk.push_back(m_pc + 16'd1);
          m_pc = vt[dec_vec];
        end else begin
          m_pc = m_pc + 16'd1; m_err = 1'b1;
        end
      end else if (br_override) m_pc = m_pc + br_offset;
      else m_pc = m_pc + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", 32'(pc), 32'(m_pc));
      chk("pc_valid", 32'(pc_valid), 32'(!m_halted));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("int_depth", 32'(int_depth), 32'(m_stk.size()));
      chk("stack_err", 32'(stack_err), 32'(m_err));
    end
  end

  // Applies one set of inputs for exactly one rising edge; returns at the next falling edge.
  task automatic cyc(input logic v, input logic h, input logic i, input logic [3:0] vec,
                     input logic b, input logic [15:0] off, input logic s, input logic w);
    dec_valid = v; dec_halt = h; dec_int = i; dec_vec = vec;
    br_override = b; br_offset = off; stall = s; wake = w;
    @(negedge clk);
  endtask

  task automatic goto_pc(input logic [15:0] target);
    logic [15:0] off;
    off = target - m_pc;
    cyc(1, 0, 0, 4'd0, 1, off, 0, 0);
  endtask

  initial begin
    cyc_init: begin
      dec_valid = 0; dec_halt = 0; dec_int = 0; dec_vec = 0;
      br_override = 0; br_offset = 0; stall = 0; wake = 0;
    end
    for (int v = 0; v < NUM_VEC; v++) vt[v] = 16'($urandom);
    vt[1] = 16'h0100;
    vt[2] = 16'h0200;
    for (int v = 0; v < NUM_VEC; v++) vec_table[v*PC_W +: PC_W] = vt[v];

    #2 n_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 n_rst = 1'b1;
    chk_en = 1'b1;
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_pc_valid", 32'(pc_valid), 32'h1);
    chk("reset_depth", 32'(int_depth), 32'h0);
    chk("reset_err", 32'(stack_err), 32'h0);

    // Sequential then stall then no-valid.
    cyc(1, 0, 0, 0, 0, 0, 0, 0); chk("seq1", 32'(pc), 32'h1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0); chk("seq2", 32'(pc), 32'h2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0); chk("seq3", 32'(pc), 32'h3);
    cyc(1, 0, 0, 0, 0, 0, 1, 0); chk("stall1", 32'(pc), 32'h3);
    cyc(1, 0, 0, 0, 0, 0, 1, 0); chk("stall2", 32'(pc), 32'h3);
    cyc(0, 0, 0, 0, 1, 16'h0040, 0, 0); chk("novalid", 32'(pc), 32'h3);

    // Branch wrap in both directions.
    goto_pc(16'h0002);
    cyc(1, 0, 0, 0, 1, 16'hFFFC, 0, 0); chk("br_back_wrap", 32'(pc), 32'hFFFE);
    goto_pc(16'hFFFF);
    cyc(1, 0, 0, 0, 1, 16'h0001, 0, 0); chk("br_fwd_wrap", 32'(pc), 32'h0);

    // Nesting to full depth, overflow, unwinding, underflow.
    goto_pc(16'h0010);
    cyc(1, 0, 1, 4'd1, 0, 0, 0, 0); chk("int1", 32'(pc), 32'h100);
    cyc(1, 0, 1, 4'd2, 0, 0, 0, 0); chk("int2", 32'(pc), 32'h200);
    chk("int2_depth", 32'(int_depth), 32'h2);
    chk("int2_err", 32'(stack_err), 32'h0);
    cyc(1, 0, 1, 4'd3, 0, 0, 0, 0); chk("int3_ovf", 32'(pc), 32'h201);
    chk("int3_err", 32'(stack_err), 32'h1);
    cyc(1, 0, 1, 4'd0, 0, 0, 0, 0); chk("ret1", 32'(pc), 32'h101);
    cyc(1, 0, 1, 4'd0, 0, 0, 0, 0); chk("ret2", 32'(pc), 32'h11);
    cyc(1, 0, 1, 4'd0, 0, 0, 0, 0); chk("ret_empty", 32'(pc), 32'h12);
    chk("ret_empty_depth", 32'(int_depth), 32'h0);

    // Interrupt beats a simultaneous branch.
    goto_pc(16'h0020);
    cyc(1, 0, 1, 4'd1, 1, 16'h0050, 0, 0); chk("prio_pc", 32'(pc), 32'h100);
    chk("prio_depth", 32'(int_depth), 32'h1);
    cyc(1, 0, 1, 4'd0, 0, 0, 0, 0); chk("prio_ret", 32'(pc), 32'h21);

    // Halt, ignored decode while halted, wake under stall; halt wins over wake when running.
    goto_pc(16'h0030);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); chk("halt_pc", 32'(pc), 32'h30);
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_valid", 32'(pc_valid), 32'h0);
    for (int k = 0; k < 4; k++)
      cyc(1, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 0);
    chk("halt_hold", 32'(pc), 32'h30);
    cyc(1, 0, 0, 0, 0, 0, 1, 1); chk("wake_pc", 32'(pc), 32'h31);
    chk("wake_flag", 32'(halted), 32'h0);
    cyc(1, 1, 0, 0, 0, 0, 0, 1); chk("halt_vs_wake", 32'(halted), 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1); chk("wake2_pc", 32'(pc), 32'h32);

    // Asynchronous reset in the middle of a nested run.
    cyc(1, 0, 1, 4'd1, 0, 0, 0, 0);
    cyc(1, 0, 1, 4'd2, 0, 0, 0, 0);
    goto_pc(16'h0042);
    chk("pre_rst_pc", 32'(pc), 32'h42);
    chk("pre_rst_depth", 32'(int_depth), 32'h2);
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst_pc", 32'(pc), 32'h0);
    chk("async_rst_depth", 32'(int_depth), 32'h0);
    chk("async_rst_err", 32'(stack_err), 32'h0);
    chk("async_rst_halted", 32'(halted), 32'h0);
    #1 n_rst = 1'b1;

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 n_rst = 1'b0;
        #1 n_rst = 1'b1;
      end
      cyc($urandom_range(0, 9) < 8,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 4) == 0,
          ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
          $urandom_range(0, 9) < 3,
          16'($urandom),
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) < 3);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
